// File: rtl/write_back_queue.sv
// Register write-back queue: buffers pending writes, drains them in order to the register
// bank and forwards the newest pending value. Optional write merging via WBQ_COALESCE_EN.
module write_back_queue #(
    parameter int DEPTH = 4
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       InValid,
    output logic       InReady,
    input  logic [2:0] InReg,
    input  logic [7:0] InDado,
    input  logic       Stall,
    output logic [2:0] RegEscr,
    output logic [7:0] DadoEscr,
    output logic       RegWrite,
    input  logic [2:0] LookReg,
    output logic       LookHit,
    output logic [7:0] LookDado,
    output logic [3:0] Count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [2:0]    fifoReg  [DEPTH];
    logic [7:0]    fifoDado [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic          doPush;
    logic          doPop;
    logic          doAppend;
    logic          mergeHit;
    logic [PW-1:0] mergeIdx;
    logic          fifoHit;
    logic [7:0]    fifoHitDado;
    logic          outHit;

    assign InReady  = (Count != DEPTH_C);
    assign doPush   = InValid && InReady;
    assign doPop    = (Count != 4'd0) && !Stall;
    assign doAppend = doPush && !mergeHit;

`ifdef WBQ_COALESCE_EN
    // The head slot leaving on this edge must not absorb the new write, or it would be lost.
    always_comb begin
        mergeHit = 1'b0;
        mergeIdx = tail;
        for (int i = 0; i < DEPTH; i++) begin
            if ((4'(i) < Count) && !(doPop && (i == 0)) &&
                (fifoReg[head + PW'(i)] == InReg)) begin
                mergeHit = 1'b1;
                mergeIdx = head + PW'(i);
            end
        end
    end
`else
    assign mergeHit = 1'b0;
    assign mergeIdx = tail;
`endif

    // Scanning oldest to newest lets the newest matching entry win.
    always_comb begin
        fifoHit     = 1'b0;
        fifoHitDado = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if ((4'(i) < Count) && (fifoReg[head + PW'(i)] == LookReg)) begin
                fifoHit     = 1'b1;
                fifoHitDado = fifoDado[head + PW'(i)];
            end
        end
    end

    assign outHit   = RegWrite && (RegEscr == LookReg);
    assign LookHit  = fifoHit || outHit;
    assign LookDado = fifoHit ? fifoHitDado : (outHit ? DadoEscr : 8'h00);

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            head     <= '0;
            tail     <= '0;
            Count    <= 4'd0;
            RegWrite <= 1'b0;
            RegEscr  <= 3'd0;
            DadoEscr <= 8'h00;
        end else begin
            if (doPop) begin
                RegEscr  <= fifoReg[head];
                DadoEscr <= fifoDado[head];
                RegWrite <= 1'b1;
                head     <= head + PW'(1);
            end else begin
                RegWrite <= 1'b0;
            end

            if (doPush) begin
                if (mergeHit) begin
                    fifoDado[mergeIdx] <= InDado;
                end else begin
                    fifoReg[tail]  <= InReg;
                    fifoDado[tail] <= InDado;
                    tail           <= tail + PW'(1);
                end
            end

            if (doAppend && !doPop) begin
                Count <= Count + 4'd1;
            end else if (!doAppend && doPop) begin
                Count <= Count - 4'd1;
            end
        end
    end

endmodule

// File: doc/write_back_queue.md
WRITE_BACK_QUEUE -- requirements
Module: write_back_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of pending write entries (power of two, 2..8).
REQ-002 SHALL have port Clock  in  1  single clock; all state updates on posedge.
REQ-003 SHALL have port Reset_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port InValid  in  1  producer write request.
REQ-005 SHALL have port InReady  out  1  queue accepts a write this cycle.
REQ-006 SHALL have port InReg  in  3  destination register index.
REQ-007 SHALL have port InDado  in  8  write data.
REQ-008 SHALL have port Stall  in  1  holds draining when high.
REQ-009 SHALL have port RegEscr  out  3  register-bank write index, registered.
REQ-010 SHALL have port DadoEscr  out  8  register-bank write data, registered.
REQ-011 SHALL have port RegWrite  out  1  register-bank write enable, registered.
REQ-012 SHALL have port LookReg  in  3  forwarding lookup index.
REQ-013 SHALL have port LookHit  out  1  a pending write to LookReg exists, combinational.
REQ-014 SHALL have port LookDado  out  8  newest pending data for LookReg, combinational; 0 when no hit.
REQ-015 SHALL have port Count  out  4  FIFO entries held, 0..DEPTH.

Function
REQ-016 SHALL set InReady = (Count != DEPTH), derived from state only, never from InValid.
REQ-017 SHALL push {InReg, InDado} at the tail on a posedge where InValid && InReady; InValid with InReady low is ignored, no state change.
REQ-018 SHALL pop the head on a posedge where Count != 0 && !Stall, loading RegEscr/DadoEscr with the head and setting RegWrite=1 for the following cycle.
REQ-019 SHALL set RegWrite=0 on any posedge with no pop; RegEscr/DadoEscr hold their last values.
REQ-020 SHALL drain strictly in push order; minimum latency: pushed at edge N, RegWrite=1 with that entry in the cycle after edge N+1.
REQ-021 SHALL allow simultaneous push and pop on one edge, Count unchanged, including when Count == DEPTH-1, and ordering preserved.
REQ-022 SHALL wrap head/tail pointers modulo DEPTH without losing or duplicating entries.
REQ-023 SHALL never push into an empty queue bypassing the FIFO; an empty queue with Stall low still yields RegWrite=0 that cycle.
REQ-024 SHALL compute LookHit over all FIFO entries plus the output stage when RegWrite=1; priority newest FIFO entry, then oldest, then output stage.
REQ-025 SHALL treat register 0 like any other index (no hardwired zero).

Reset
REQ-026 SHALL, on posedge with Reset_n=0, clear Count, head and tail to 0, RegWrite, RegEscr, DadoEscr to 0, discarding all pending entries.
REQ-027 SHALL give reset priority over InValid and pop; no push or drain on a reset edge.
REQ-028 SHALL drive InReady=1 and LookHit=0 in the cycle after reset.

Configuration
REQ-029 SHALL, with macro WBQ_COALESCE_EN defined, overwrite InDado into the newest FIFO entry whose register equals InReg on push (Count unchanged) instead of appending; entries being popped on the same edge are excluded from matching.
REQ-030 SHALL, without WBQ_COALESCE_EN, always append on push; InReady rule of REQ-016 is identical in both builds.

Verification
REQ-031 SHALL verify: reset, push (3,0x44) with Stall=0 -> RegWrite=1, RegEscr=3, DadoEscr=0x44 exactly one cycle, two edges after push; Count back to 0.
REQ-032 SHALL verify: Stall=1, push regs 1..4 data 0x11..0x14 -> Count=4, InReady=0, 5th push ignored; release Stall -> four consecutive RegWrite cycles in order 1..4.
REQ-033 SHALL verify: queue holds (2,0x20),(5,0x50),(2,0x22), LookReg=2 -> LookHit=1, LookDado=0x22; LookReg=6 -> LookHit=0, LookDado=0.
REQ-034 SHALL verify: Count=3 with Stall=0, push and pop same edge for 10 cycles -> Count stays 3, outputs match push order across pointer wrap.
REQ-035 SHALL verify: Reset_n=0 asserted with Count=2 and InValid=1 -> next cycle Count=0, RegWrite=0, no entry later drained.
REQ-036 SHALL verify with WBQ_COALESCE_EN: Stall=1, push (4,0x01) then (4,0x02) -> Count=1; release -> single write reg 4 data 0x02; without macro -> two writes 0x01, 0x02.
